// File: rtl/tbird_seq_if.sv
// tbird_seq_if
//   Driver-control / lamp bundle for the tail-light sequencer.
//   master: the debounced control source (drives requests, observes lamps).
//   slave : the sequencer (samples requests, drives lamps and busy).
//   Signals:
//     left, right, hazard, brake  control requests (level)
//     l_lamps, r_lamps            lamp outputs, bit0 innermost
//     busy                        sequencer not idle
interface tbird_seq_if #(
    parameter int N_LAMPS = 3
);
    logic               left;
    logic               right;
    logic               hazard;
    logic               brake;
    logic [N_LAMPS-1:0] l_lamps;
    logic [N_LAMPS-1:0] r_lamps;
    logic               busy;

    modport master (
        output left, right, hazard, brake,
        input  l_lamps, r_lamps, busy
    );

    modport slave (
        input  left, right, hazard, brake,
        output l_lamps, r_lamps, busy
    );
endinterface

// File: rtl/tbird_seq.sv
// tbird_seq
//   Parametrised tail-light sequencer: N_LAMPS per side, a prescaler setting
//   the step rate, hazard flashing and brake override.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-low
//     bus    tbird_seq_if.slave: left/right/hazard/brake in,
//            l_lamps/r_lamps/busy out
//   Parameters:
//     N_LAMPS   lamps per side (>= 1), index 0 lights first
//     TICK_DIV  clock cycles per sequence step (>= 1)
module tbird_seq #(
    parameter int N_LAMPS  = 3,
    parameter int TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    tbird_seq_if.slave bus
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(N_LAMPS + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(N_LAMPS);

    typedef enum logic [2:0] {
        IDLE,
        LEFT,
        RIGHT,
        HAZ_ON,
        HAZ_OFF
    } state_t;

    state_t             state, state_nx;
    logic [SW-1:0]      step, step_nx;
    logic [CW-1:0]      cnt;
    logic               tick;
    logic               brake_q;
    logic               haz_req;
    logic [N_LAMPS-1:0] therm;
    logic [N_LAMPS-1:0] brake_mask;
    logic [N_LAMPS-1:0] l_d, r_d;

    // With TICK_DIV == 1 the counter stays at 0 and tick is permanently high.
    assign tick    = (cnt == CNT_LAST);
    assign haz_req = bus.hazard | (bus.left & bus.right);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // brake_q follows the pedal every cycle, independent of the step tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            step    <= '0;
            brake_q <= 1'b0;
        end else begin
            state   <= state_nx;
            step    <= step_nx;
            brake_q <= bus.brake;
        end
    end

    always_comb begin
        state_nx = state;
        step_nx  = step;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (haz_req) begin
                        state_nx = HAZ_ON;
                    end else if (bus.left) begin
                        state_nx = LEFT;
                        step_nx  = SW'(1);
                    end else if (bus.right) begin
                        state_nx = RIGHT;
                        step_nx  = SW'(1);
                    end
                end
                LEFT, RIGHT: begin
                    if (haz_req) begin
                        state_nx = HAZ_ON;
                        step_nx  = '0;
                    end else if (step == STEP_LAST) begin
                        state_nx = IDLE;
                        step_nx  = '0;
                    end else begin
                        step_nx = step + SW'(1);
                    end
                end
                HAZ_ON: begin
                    state_nx = HAZ_OFF;
                end
                HAZ_OFF: begin
                    state_nx = haz_req ? HAZ_ON : IDLE;
                end
                default: begin
                    state_nx = IDLE;
                    step_nx  = '0;
                end
            endcase
        end
    end

    // Thermometer code: the low 'step' lamps are lit.
    always_comb begin
        therm = '0;
        for (int unsigned i = 0; i < N_LAMPS; i++) begin
            therm[i] = (i < 32'(step));
        end
    end

    assign brake_mask = brake_q ? '1 : '0;

    // Hazard states ignore brake entirely.
    always_comb begin
        l_d = '0;
        r_d = '0;
        case (state)
            IDLE: begin
                l_d = brake_mask;
                r_d = brake_mask;
            end
            LEFT: begin
                l_d = therm;
                r_d = brake_mask;
            end
            RIGHT: begin
                l_d = brake_mask;
                r_d = therm;
            end
            HAZ_ON: begin
                l_d = '1;
                r_d = '1;
            end
            default: begin
                l_d = '0;
                r_d = '0;
            end
        endcase
    end

    assign bus.l_lamps = l_d;
    assign bus.r_lamps = r_d;
    assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_tbird_seq.sv
// tb_tbird_seq
//   Two sequencer instances: A (N_LAMPS=3, TICK_DIV=1) driven from a vector
//   table, B (N_LAMPS=5, TICK_DIV=4) driven by a hand-written sequence.
//   Expected outputs are queued when stimulus is applied and popped after the
//   following rising edge.
module tb_tbird_seq;
    logic clk;
    logic rst_a, rst_b;

    tbird_seq_if #(.N_LAMPS(3)) ia ();
    tbird_seq_if #(.N_LAMPS(5)) ib ();

    tbird_seq #(.N_LAMPS(3), .TICK_DIV(1)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ia.slave)
    );

    tbird_seq #(.N_LAMPS(5), .TICK_DIV(4)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ib.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       left;
        logic       right;
        logic       hazard;
        logic       brake;
        logic [7:0] l;
        logic [7:0] r;
        logic       busy;
    } vec_t;

    typedef struct {
        logic [7:0] l;
        logic [7:0] r;
        logic       busy;
    } exp_t;

    vec_t vtab[$];
    exp_t sb[$];
    int   checks;
    int   failures;

    task automatic row(input logic rn, input logic lf, input logic rt, input logic hz,
                       input logic bk, input logic [7:0] el, input logic [7:0] er,
                       input logic eb);
        vtab.push_back('{rn, lf, rt, hz, bk, el, er, eb});
    endtask

    task automatic chk(input string what, input int idx, input logic [7:0] act,
                       input logic [7:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s[%0d] got=%b want=%b", what, idx, act, want);
        end
    endtask

    task automatic pop_cmp(input string tag, input int idx, input logic [7:0] al,
                           input logic [7:0] ar, input logic ab);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_sb_underflow[%0d] got=empty want=entry", tag, idx);
        end else begin
            e = sb.pop_front();
            chk({tag, "_l"}, idx, al, e.l);
            chk({tag, "_r"}, idx, ar, e.r);
            chk({tag, "_busy"}, idx, 8'(ab), 8'(e.busy));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        exp_t e;
        checks   = 0;
        failures = 0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        {ia.left, ia.right, ia.hazard, ia.brake} = 4'b0;
        {ib.left, ib.right, ib.hazard, ib.brake} = 4'b0;

        //  rst L R H B   l        r        busy
        row(0, 0,0,0,0, 8'b000, 8'b000, 0);   // 0  reset state
        row(1, 1,0,0,0, 8'b001, 8'b000, 1);   // 1  left held from release
        row(1, 1,0,0,0, 8'b011, 8'b000, 1);
        row(1, 1,0,0,0, 8'b111, 8'b000, 1);
        row(1, 1,0,0,0, 8'b000, 8'b000, 0);   // 4  back to idle
        row(1, 1,0,0,0, 8'b001, 8'b000, 1);
        row(1, 0,0,0,0, 8'b011, 8'b000, 1);   // 6  left dropped, sequence completes
        row(1, 0,0,0,0, 8'b111, 8'b000, 1);
        row(1, 0,0,0,0, 8'b000, 8'b000, 0);
        row(1, 0,0,0,0, 8'b000, 8'b000, 0);
        row(1, 1,1,0,0, 8'b111, 8'b111, 1);   // 10 left+right = hazard
        row(1, 1,1,0,0, 8'b000, 8'b000, 1);
        row(1, 1,1,0,0, 8'b111, 8'b111, 1);
        row(1, 0,0,0,0, 8'b000, 8'b000, 1);
        row(1, 0,0,0,0, 8'b000, 8'b000, 0);
        row(1, 0,0,1,0, 8'b111, 8'b111, 1);   // 15 hazard alone
        row(1, 0,0,1,0, 8'b000, 8'b000, 1);
        row(1, 0,0,0,0, 8'b000, 8'b000, 0);
        row(1, 1,0,0,0, 8'b001, 8'b000, 1);   // 18 hazard preempts at l=011
        row(1, 1,0,0,0, 8'b011, 8'b000, 1);
        row(1, 1,0,1,0, 8'b111, 8'b111, 1);
        row(1, 1,0,0,0, 8'b000, 8'b000, 1);
        row(1, 1,0,0,0, 8'b000, 8'b000, 0);
        row(1, 0,0,0,0, 8'b000, 8'b000, 0);
        row(1, 0,0,0,1, 8'b111, 8'b111, 0);   // 24 brake while idle
        row(1, 1,0,0,1, 8'b001, 8'b111, 1);
        row(1, 1,0,0,1, 8'b011, 8'b111, 1);
        row(1, 0,0,0,1, 8'b111, 8'b111, 1);
        row(1, 0,0,0,0, 8'b000, 8'b000, 0);
        row(1, 0,0,1,1, 8'b111, 8'b111, 1);   // 29 hazard dominates brake
        row(1, 0,0,0,1, 8'b000, 8'b000, 1);
        row(1, 0,0,0,1, 8'b111, 8'b111, 0);
        row(1, 0,1,0,0, 8'b000, 8'b001, 1);   // 32 right, brake on left side
        row(1, 0,1,0,0, 8'b000, 8'b011, 1);
        row(1, 0,0,0,1, 8'b111, 8'b111, 1);
        row(1, 0,0,0,0, 8'b000, 8'b000, 0);
        row(1, 1,0,0,0, 8'b001, 8'b000, 1);   // 36 reset mid-sequence
        row(1, 1,0,0,0, 8'b011, 8'b000, 1);
        row(0, 1,0,0,0, 8'b000, 8'b000, 0);
        row(1, 1,0,0,0, 8'b001, 8'b000, 1);
        row(1, 1,0,0,0, 8'b011, 8'b000, 1);
        row(0, 0,0,0,1, 8'b000, 8'b000, 0);   // 41 reset also clears brake_q
        row(1, 0,0,0,0, 8'b000, 8'b000, 0);

        // Instance A: table-driven, tick every cycle.
        for (int i = 0; i < vtab.size(); i++) begin
            @(negedge clk);
            rst_a     = vtab[i].rst_n;
            ia.left   = vtab[i].left;
            ia.right  = vtab[i].right;
            ia.hazard = vtab[i].hazard;
            ia.brake  = vtab[i].brake;
            sb.push_back('{vtab[i].l, vtab[i].r, vtab[i].busy});
            @(posedge clk);
            #1;
            pop_cmp("A", i, 8'(ia.l_lamps), 8'(ia.r_lamps), ia.busy);
        end

        // Instance B has been held in reset throughout.
        chk("B_reset_l", 0, 8'(ib.l_lamps), 8'h00);
        chk("B_reset_r", 0, 8'(ib.r_lamps), 8'h00);
        chk("B_reset_busy", 0, 8'(ib.busy), 8'h00);

        // Instance B: release reset, hold right across the first tick only.
        // First tick lands on the 4th edge after release; each step then lasts
        // 4 cycles. A one-cycle left pulse off-tick must be ignored; a brake
        // pulse shows up one cycle later regardless of the tick.
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            rst_b     = 1'b1;
            ib.right  = (k <= 4);
            ib.left   = (k == 25);
            ib.brake  = (k == 26);
            ib.hazard = 1'b0;
            e.l = 8'h00;
            e.r = 8'h00;
            e.busy = 1'b0;
            if (k >= 4) begin
                s = (k - 4) / 4 + 1;
                if (s <= 5) begin
                    e.r    = 8'((1 << s) - 1);
                    e.busy = 1'b1;
                end
            end
            if (k == 26) begin
                e.l = 8'h1F;
                e.r = 8'h1F;
            end
            sb.push_back(e);
            @(posedge clk);
            #1;
            pop_cmp("B", k, 8'(ib.l_lamps), 8'(ib.r_lamps), ib.busy);
        end

        chk("sb_empty", 0, 8'(sb.size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
